// File: rtl/tx_drain.sv
// Purpose : drains destination FIFOs D0/D1 under round-robin arbitration into
//           one tagged ready/valid stream {src, payload}; MSB 0 = D0, 1 = D1.
// Latency : pop in cycle n, FIFO data in n+1, VALID_OUT in n+2 (skid empty).
// Backpr. : a 3-entry skid absorbs the FIFO read latency; pops stop once
//           skid occupancy plus the in-flight word reaches 3, so nothing is lost.
// Ports   : clk/RESET (sync, active-high); D0_*/D1_* FIFO read side with
//           POP_D0/POP_D1; DATA_OUT/VALID_OUT/READY_IN output stream; IDLE status;
//           REQ/IDX -> CNT_OUT/CNT_VALID statistics read port.
// Config  : TX_DRAIN_STATS_EN enables the per-source and total word counters.
//           Without it CNT_OUT/CNT_VALID are tied to 0 and REQ/IDX are ignored.
module tx_drain #(
    parameter int DATA_W = 6,
    parameter int CNT_W  = 5
) (
    input  logic              clk,
    input  logic              RESET,
    input  logic [DATA_W-1:0] D0_data,
    input  logic              D0_empty,
    input  logic [DATA_W-1:0] D1_data,
    input  logic              D1_empty,
    input  logic              READY_IN,
    output logic              POP_D0,
    output logic              POP_D1,
    output logic [DATA_W:0]   DATA_OUT,
    output logic              VALID_OUT,
    output logic              IDLE,
    input  logic              REQ,
    input  logic [1:0]        IDX,
    output logic [CNT_W-1:0]  CNT_OUT,
    output logic              CNT_VALID
);

    typedef enum logic [1:0] {ST_RST, ST_IDLE, ST_ACTIVE} state_t;

    state_t          state;
    logic            inflight;      // a pop was issued last cycle
    logic            inflight_src;  // which FIFO that pop went to
    logic            rr_ptr;        // 0 = D0 has priority, 1 = D1
    logic [DATA_W:0] skid [3];
    logic [1:0]      head;
    logic [1:0]      tail;
    logic [1:0]      occ;

    logic [2:0] pending;
    logic       run;
    logic       credit;
    logic       elig0;
    logic       elig1;
    logic       grant0;
    logic       grant1;
    logic       enq;
    logic       deq;
    logic       quiet;

    function automatic logic [1:0] nxt(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Pops are decided combinationally from the current empty flags: the flags
    // update on the same edge as a pop, so a registered pop would re-pop a FIFO
    // that just went empty.
    assign run     = (state != ST_RST) && !RESET;
    assign pending = {1'b0, occ} + {2'b00, inflight};
    assign credit  = pending < 3'd3;
    assign elig0   = run && !D0_empty && credit;
    assign elig1   = run && !D1_empty && credit;
    assign grant0  = elig0 && (!elig1 || !rr_ptr);
    assign grant1  = elig1 && (!elig0 ||  rr_ptr);
    assign POP_D0  = grant0;
    assign POP_D1  = grant1;

    assign VALID_OUT = (occ != 2'd0);
    assign DATA_OUT  = VALID_OUT ? skid[head] : '0;
    assign enq       = inflight;
    assign deq       = VALID_OUT && READY_IN;

    assign quiet = D0_empty && D1_empty && !inflight && (occ == 2'd0);
    assign IDLE  = (state != ST_RST) && quiet;

    always_ff @(posedge clk) begin
        if (RESET) begin
            state        <= ST_RST;
            inflight     <= 1'b0;
            inflight_src <= 1'b0;
            rr_ptr       <= 1'b0;
            head         <= 2'd0;
            tail         <= 2'd0;
            occ          <= 2'd0;
        end else begin
            case (state)
                ST_RST:    state <= ST_IDLE;
                ST_IDLE:   if (!D0_empty || !D1_empty) state <= ST_ACTIVE;
                ST_ACTIVE: if (quiet) state <= ST_IDLE;
                default:   state <= ST_RST;
            endcase

            inflight     <= grant0 || grant1;
            inflight_src <= grant1;

            // The pointer always moves away from whichever side was granted.
            if (grant0)      rr_ptr <= 1'b1;
            else if (grant1) rr_ptr <= 1'b0;

            if (enq) tail <= nxt(tail);
            if (deq) head <= nxt(head);
            case ({enq, deq})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

    // Skid storage needs no reset: occupancy alone qualifies its contents.
    always_ff @(posedge clk) begin
        if (enq && !RESET)
            skid[tail] <= {inflight_src, inflight_src ? D1_data : D0_data};
    end

    // The credit check must make a skid overflow impossible.
    assert property (@(posedge clk) disable iff (RESET)
        !(enq && !deq && (occ == 2'd3)));
    assert property (@(posedge clk) !(POP_D0 && POP_D1));

`ifdef TX_DRAIN_STATS_EN
    logic [CNT_W-1:0] cnt_d0;
    logic [CNT_W-1:0] cnt_d1;
    logic [CNT_W-1:0] cnt_tot;
    logic [CNT_W-1:0] cnt_q;
    logic             cnt_vld_q;

    // A read in the same cycle as an increment returns the pre-increment value
    // because both sample the counters before the edge.
    always_ff @(posedge clk) begin
        if (RESET) begin
            cnt_d0    <= '0;
            cnt_d1    <= '0;
            cnt_tot   <= '0;
            cnt_q     <= '0;
            cnt_vld_q <= 1'b0;
        end else begin
            if (deq) begin
                cnt_tot <= cnt_tot + CNT_W'(1);
                if (DATA_OUT[DATA_W]) cnt_d1 <= cnt_d1 + CNT_W'(1);
                else                  cnt_d0 <= cnt_d0 + CNT_W'(1);
            end
            cnt_vld_q <= REQ;
            if (REQ) begin
                case (IDX)
                    2'd0:    cnt_q <= cnt_d0;
                    2'd1:    cnt_q <= cnt_d1;
                    2'd2:    cnt_q <= cnt_tot;
                    default: cnt_q <= '0;
                endcase
            end
        end
    end

    assign CNT_OUT   = cnt_q;
    assign CNT_VALID = cnt_vld_q;
`else
    logic unused_stats;
    assign unused_stats = ^{REQ, IDX};
    assign CNT_OUT      = '0;
    assign CNT_VALID    = 1'b0;
`endif

endmodule

// File: tb/tb_tx_drain.sv
// Purpose : directed bench for tx_drain with behavioural D0/D1 FIFO models.
// Latency : FIFO models return data the cycle after a pop; empty updates on that edge.
// Backpr. : READY_IN is driven by the scenario tasks.
module tb_tx_drain;
    localparam int DATA_W = 6;
    localparam int CNT_W  = 5;

    logic              clk = 1'b0;
    logic              RESET;
    logic [DATA_W-1:0] D0_data = '0;
    logic              D0_empty;
    logic [DATA_W-1:0] D1_data = '0;
    logic              D1_empty;
    logic              READY_IN;
    logic              POP_D0;
    logic              POP_D1;
    logic [DATA_W:0]   DATA_OUT;
    logic              VALID_OUT;
    logic              IDLE;
    logic              REQ;
    logic [1:0]        IDX;
    logic [CNT_W-1:0]  CNT_OUT;
    logic              CNT_VALID;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    tx_drain #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .RESET(RESET),
        .D0_data(D0_data), .D0_empty(D0_empty),
        .D1_data(D1_data), .D1_empty(D1_empty),
        .READY_IN(READY_IN), .POP_D0(POP_D0), .POP_D1(POP_D1),
        .DATA_OUT(DATA_OUT), .VALID_OUT(VALID_OUT), .IDLE(IDLE),
        .REQ(REQ), .IDX(IDX), .CNT_OUT(CNT_OUT), .CNT_VALID(CNT_VALID)
    );

    // FIFO models: written only by tasks (wr side) and the pop process (rd side).
    logic [DATA_W-1:0] mem0 [0:127];
    logic [DATA_W-1:0] mem1 [0:127];
    int wr0 = 0, rd0 = 0, wr1 = 0, rd1 = 0;

    assign D0_empty = (rd0 >= wr0);
    assign D1_empty = (rd1 >= wr1);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (POP_D0 && rd0 < wr0) begin D0_data <= mem0[rd0]; rd0 <= rd0 + 1; end
        if (POP_D1 && rd1 < wr1) begin D1_data <= mem1[rd1]; rd1 <= rd1 + 1; end
    end

    // Per-cycle history sampled on the falling edge, plus the delivered stream.
    logic          h_pop0 [0:4095];
    logic          h_pop1 [0:4095];
    logic          h_vld  [0:4095];
    logic          h_idle [0:4095];
    logic [DATA_W:0] h_dat [0:4095];
    logic [DATA_W:0] outq [$];
    int              outc [$];

    always @(negedge clk) begin
        if (cyc < 4096) begin
            h_pop0[cyc] = POP_D0;
            h_pop1[cyc] = POP_D1;
            h_vld[cyc]  = VALID_OUT;
            h_idle[cyc] = IDLE;
            h_dat[cyc]  = DATA_OUT;
        end
        if (VALID_OUT && READY_IN && !RESET) begin
            outq.push_back(DATA_OUT);
            outc.push_back(cyc);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push0(input logic [DATA_W-1:0] v);
        mem0[wr0] = v;
        wr0 = wr0 + 1;
    endtask

    task automatic push1(input logic [DATA_W-1:0] v);
        mem1[wr1] = v;
        wr1 = wr1 + 1;
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        step();
        step();
        RESET = 1'b0;
        step();
        step();
    endtask

    task automatic test_reset();
        RESET = 1'b1; READY_IN = 1'b1; REQ = 1'b0; IDX = 2'd0;
        step();
        @(negedge clk);
        checks++; if (POP_D0 !== 1'b0)    begin errors++; $display("FAIL rst_pop_d0 got=%b exp=0", POP_D0); end
        checks++; if (POP_D1 !== 1'b0)    begin errors++; $display("FAIL rst_pop_d1 got=%b exp=0", POP_D1); end
        checks++; if (VALID_OUT !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b exp=0", VALID_OUT); end
        checks++; if (DATA_OUT !== 7'd0)  begin errors++; $display("FAIL rst_data got=%h exp=0", DATA_OUT); end
        checks++; if (IDLE !== 1'b0)      begin errors++; $display("FAIL rst_idle got=%b exp=0", IDLE); end
        checks++; if (CNT_OUT !== 5'd0)   begin errors++; $display("FAIL rst_cnt_out got=%h exp=0", CNT_OUT); end
        checks++; if (CNT_VALID !== 1'b0) begin errors++; $display("FAIL rst_cnt_valid got=%b exp=0", CNT_VALID); end
        step();
        RESET = 1'b0;
        step();
        step();
        @(negedge clk);
        checks++; if (IDLE !== 1'b1) begin errors++; $display("FAIL idle_after_reset got=%b exp=1", IDLE); end
        checks++; if ({POP_D0, POP_D1} !== 2'b00) begin errors++; $display("FAIL idle_no_pop got=%b%b exp=00", POP_D0, POP_D1); end
    endtask

    task automatic test_single_word();
        int c, n, npop;
        c = cyc;
        push0(6'b101010);
        repeat (8) step();
        n = -1; npop = 0;
        for (int i = c; i <= c + 6; i++) begin
            if (h_pop0[i] === 1'b1 && n < 0) n = i;
            if (h_pop0[i] === 1'b1) npop++;
            if (h_pop1[i] === 1'b1) npop++;
        end
        checks++; if (n < 0) begin errors++; $display("FAIL single_pop_seen got=none exp=POP_D0"); n = c; end
        checks++; if (npop != 1) begin errors++; $display("FAIL single_pop_count got=%0d exp=1", npop); end
        checks++; if (h_vld[n+1] !== 1'b0) begin errors++; $display("FAIL single_early_valid got=%b exp=0", h_vld[n+1]); end
        checks++; if (h_vld[n+2] !== 1'b1 || h_dat[n+2] !== 7'b0101010) begin
            errors++; $display("FAIL single_data got=%b/%b exp=1/0101010", h_vld[n+2], h_dat[n+2]); end
        checks++; if (h_idle[n+2] !== 1'b0 || h_idle[n+3] !== 1'b1) begin
            errors++; $display("FAIL single_idle got=%b%b exp=01", h_idle[n+2], h_idle[n+3]); end
    endtask

    task automatic test_round_robin();
        int c, n;
        logic [DATA_W:0] exp_w [0:5];
        exp_w = '{7'h01, 7'h51, 7'h02, 7'h52, 7'h03, 7'h53};
        do_reset();
        c = cyc;
        push0(6'h01); push0(6'h02); push0(6'h03);
        push1(6'h11); push1(6'h12); push1(6'h13);
        repeat (14) step();
        n = -1;
        for (int i = c; i <= c + 3; i++) if (n < 0 && (h_pop0[i] === 1'b1 || h_pop1[i] === 1'b1)) n = i;
        checks++; if (n < 0) begin errors++; $display("FAIL rr_pop_seen got=none exp=pop"); n = c; end
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (h_pop0[n+k] !== ((k % 2) == 0) || h_pop1[n+k] !== ((k % 2) == 1)) begin
                errors++; $display("FAIL rr_pop_order k=%0d got=%b%b exp=%0d", k, h_pop0[n+k], h_pop1[n+k], k % 2); end
        end
        checks++; if (h_pop0[n+6] !== 1'b0 || h_pop1[n+6] !== 1'b0) begin
            errors++; $display("FAIL rr_extra_pop got=%b%b exp=00", h_pop0[n+6], h_pop1[n+6]); end
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (h_vld[n+2+k] !== 1'b1 || h_dat[n+2+k] !== exp_w[k]) begin
                errors++; $display("FAIL rr_out k=%0d got=%b/%h exp=1/%h", k, h_vld[n+2+k], h_dat[n+2+k], exp_w[k]); end
        end
    endtask

    task automatic test_backpressure();
        int c, base, npop, bad;
        do_reset();
        READY_IN = 1'b0;
        base = outq.size();
        c = cyc;
        for (int k = 0; k < 5; k++) push1(6'(5 + k));
        repeat (10) step();
        READY_IN = 1'b1;
        repeat (20) step();
        npop = 0;
        for (int i = c; i <= c + 9; i++) if (h_pop1[i] === 1'b1 || h_pop0[i] === 1'b1) npop++;
        checks++; if (npop != 3) begin errors++; $display("FAIL bp_stall_pops got=%0d exp=3", npop); end
        bad = 0;
        for (int i = c + 2; i <= c + 9; i++) if (h_vld[i] !== 1'b1 || h_dat[i] !== 7'h45) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL bp_stable got=%0d_bad_cycles exp=0", bad); end
        checks++; if (outq.size() - base != 5) begin errors++; $display("FAIL bp_count got=%0d exp=5", outq.size() - base); end
        for (int k = 0; k < 5 && base + k < outq.size(); k++) begin
            checks++;
            if (outq[base+k] !== {1'b1, 6'(5 + k)}) begin
                errors++; $display("FAIL bp_order k=%0d got=%h exp=%h", k, outq[base+k], {1'b1, 6'(5 + k)}); end
            checks++;
            if (outc[base+k] < c + 10) begin
                errors++; $display("FAIL bp_early k=%0d got=cyc%0d exp>=cyc%0d", k, outc[base+k], c + 10); end
        end
    endtask

    task automatic test_counters();
        int base;
        logic [1:0] idx_seq [0:3];
        logic [CNT_W-1:0] exp_c [0:3];
        idx_seq = '{2'd3, 2'd0, 2'd1, 2'd2};
        exp_c   = '{5'd0, 5'd1, 5'd2, 5'd3};
        do_reset();
        base = outq.size();
`ifdef TX_DRAIN_STATS_EN
        for (int k = 0; k < 33; k++) push0(6'(k));
        push1(6'h2a); push1(6'h2b);
        repeat (50) step();
        checks++; if (outq.size() - base != 35) begin errors++; $display("FAIL cnt_delivered got=%0d exp=35", outq.size() - base); end
        for (int k = 0; k < 4; k++) begin
            IDX = idx_seq[k]; REQ = 1'b1;
            step();
            REQ = 1'b0;
            @(negedge clk);
            checks++;
            if (CNT_VALID !== 1'b1 || CNT_OUT !== exp_c[k]) begin
                errors++; $display("FAIL cnt_read idx=%0d got=%b/%0d exp=1/%0d", idx_seq[k], CNT_VALID, CNT_OUT, exp_c[k]); end
        end
        step();
        @(negedge clk);
        checks++; if (CNT_VALID !== 1'b0 || CNT_OUT !== 5'd3) begin
            errors++; $display("FAIL cnt_hold got=%b/%0d exp=0/3", CNT_VALID, CNT_OUT); end
`else
        push0(6'h0a); push0(6'h0b);
        repeat (8) step();
        checks++; if (outq.size() - base != 2) begin errors++; $display("FAIL nostats_delivered got=%0d exp=2", outq.size() - base); end
        IDX = 2'd2; REQ = 1'b1;
        step();
        REQ = 1'b0;
        @(negedge clk);
        checks++; if (CNT_VALID !== 1'b0 || CNT_OUT !== 5'd0) begin
            errors++; $display("FAIL nostats_read got=%b/%0d exp=0/0", CNT_VALID, CNT_OUT); end
        checks++; if (idx_seq[0] !== 2'd3 || exp_c[3] !== 5'd3) begin
            errors++; $display("FAIL nostats_tables got=%0d/%0d exp=3/3", idx_seq[0], exp_c[3]); end
`endif
    endtask

    task automatic test_reset_midstream();
        int c, n, base, pre, first, bad, npost, post_pop;
        do_reset();
        base = outq.size();
        c = cyc;
        for (int k = 0; k < 6; k++) begin push0(6'(32 + k)); push1(6'(48 + k)); end
        n = -1;
        for (int i = 0; i < 4 && n < 0; i++) begin
            @(negedge clk);
            if (POP_D0 || POP_D1) n = cyc;
        end
        checks++; if (n < 0) begin errors++; $display("FAIL mid_pop_seen got=none exp=pop"); n = c; end
        step(); step(); step();          // now in cycle n+3, one cycle after the pop at n+2
        RESET = 1'b1;
        step();
        RESET = 1'b0; IDX = 2'd2; REQ = 1'b1;
        step();
        REQ = 1'b0;
        @(negedge clk);
`ifdef TX_DRAIN_STATS_EN
        checks++; if (CNT_VALID !== 1'b1 || CNT_OUT !== 5'd0) begin
            errors++; $display("FAIL mid_cnt_clear got=%b/%0d exp=1/0", CNT_VALID, CNT_OUT); end
`endif
        repeat (25) step();
        checks++; if (h_vld[n+4] !== 1'b0) begin errors++; $display("FAIL mid_valid_after_reset got=%b exp=0", h_vld[n+4]); end
        pre = 0; first = -1; bad = 0; npost = 0;
        for (int k = base; k < outq.size(); k++) begin
            if (outc[k] < n + 3) pre++;
            else begin
                npost++;
                if (first < 0) first = k;
            end
            if (outq[k] === 7'h21 || outq[k] === 7'h70) bad++;
        end
        checks++; if (pre != 1 || outq[base] !== 7'h20) begin
            errors++; $display("FAIL mid_pre_reset got=%0d/%h exp=1/20", pre, outq[base]); end
        checks++; if (bad != 0) begin errors++; $display("FAIL mid_discarded_seen got=%0d exp=0", bad); end
        checks++; if (first < 0 || outq[first] !== 7'h22) begin
            errors++; $display("FAIL mid_first_after got=%h exp=22", (first < 0) ? 7'h7f : outq[first]); end
        post_pop = -1;
        for (int i = n + 4; i < n + 12; i++)
            if (post_pop < 0 && (h_pop0[i] === 1'b1 || h_pop1[i] === 1'b1)) post_pop = h_pop1[i] ? 1 : 0;
        checks++; if (post_pop != 0) begin errors++; $display("FAIL mid_ptr_reset got=%0d exp=0", post_pop); end
        checks++; if (npost != (wr0 - 2) + (wr1 - 1) - (base - base) - ((wr0 - 6) + (wr1 - 6))) begin
            errors++; $display("FAIL mid_post_count got=%0d exp=%0d", npost, 9); end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_round_robin();
        test_backpressure();
        test_counters();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tx_drain.md
# tx_drain

Downstream consumer of the transmitter's two destination FIFOs, D0 and D1. It issues POP_D0/POP_D1 under round-robin arbitration, absorbs the FIFOs' one-cycle read latency in a 3-entry skid buffer, and emits a single tagged stream with ready/valid backpressure. Optional per-destination word counters can be read back through a request/index port.

## Interface
- DATA_W, 6, payload width of each D FIFO word
- CNT_W, 5, width of each statistics counter
- clk  in  1  single clock, all logic on rising edge
- RESET  in  1  synchronous, active-high reset
- D0_data  in  DATA_W  D0 FIFO read data, valid the cycle after POP_D0
- D0_empty  in  1  D0 FIFO empty flag, registered, updated on the same edge as a pop
- D1_data  in  DATA_W  D1 FIFO read data, valid the cycle after POP_D1
- D1_empty  in  1  D1 FIFO empty flag, same rules as D0_empty
- READY_IN  in  1  downstream accepts DATA_OUT this cycle
- POP_D0  out  1  pop request to D0 FIFO
- POP_D1  out  1  pop request to D1 FIFO
- DATA_OUT  out  DATA_W+1  {source bit, payload}; MSB is 0 for D0, 1 for D1
- VALID_OUT  out  1  DATA_OUT holds a word
- IDLE  out  1  both FIFOs empty, nothing in flight, skid empty
- REQ  in  1  counter read request
- IDX  in  2  counter select: 0 = D0, 1 = D1, 2 = total, 3 = reserved (returns 0)
- CNT_OUT  out  CNT_W  counter read data
- CNT_VALID  out  1  CNT_OUT valid

## Operation
- States are RST, IDLE, ACTIVE.
  - RESET forces RST. RST moves to IDLE on the first cycle RESET is low.
  - IDLE moves to ACTIVE when either empty flag is low.
  - ACTIVE moves to IDLE when IDLE would be 1.
- Pop eligibility: a pop is issued only if the target's empty flag is 0 and skid_occ + inflight < 3.
  - skid_occ is the count at the start of the cycle, before any dequeue.
  - inflight is 1 if a pop was issued in the previous cycle.
- At most one pop per cycle. POP_D0 and POP_D1 are never high together.
- Round-robin pointer:
  - If both FIFOs are eligible, the pointer side wins.
  - After any grant, the pointer moves to the other side.
  - If only one side is eligible, it is granted and the pointer still toggles away from it.
  - The pointer resets to D0.
- Capture: the cycle after a pop, {src, Dx_data} is written to the skid tail.
- Skid is a 3-entry FIFO.
  - DATA_OUT/VALID_OUT show its head.
  - The head dequeues on VALID_OUT & READY_IN.
  - Enqueue and dequeue in the same cycle are allowed.
  - Overflow cannot occur by construction. Verification asserts this.
- DATA_OUT is held stable while VALID_OUT=1 and READY_IN=0.
- Counters increment on VALID_OUT & READY_IN: the source counter and the total counter, each by 1. They wrap mod 2^CNT_W.
- Counter read: REQ in cycle n gives CNT_OUT = selected counter value at the start of n, with CNT_VALID=1, in cycle n+1. If no REQ, CNT_VALID=0 and CNT_OUT holds its last value.

## Timing
- Reset values:
  - POP_D0=0, POP_D1=0, VALID_OUT=0, DATA_OUT=0, IDLE=0 (in RST), CNT_OUT=0, CNT_VALID=0.
  - Counters=0, skid empty, inflight=0, pointer=D0.
- IDLE=1 from the first cycle after reset deassertion, if the FIFOs are empty.
- Latency: pop in cycle n, FIFO data in n+1, VALID_OUT in n+2 (skid empty, no backlog).
- Sustained throughput is 1 word/cycle while READY_IN=1 and any FIFO is non-empty.
- Single-word FIFO: a pop at n makes the empty flag 1 at n+1, so no second pop is issued to it.
- READY_IN low:
  - Pops stop once skid_occ + inflight reaches 3.
  - No data is lost.
  - Pops resume in the cycle READY_IN returns high and the credit condition holds.
- Reset mid-operation:
  - The in-flight word and all skid contents are discarded.
  - Counters clear.
  - Pops are 0 from the cycle after RESET is sampled high.
- A counter increment and a REQ in the same cycle: the read returns the pre-increment value.

## Configuration
- TX_DRAIN_STATS_EN defined: counters and the REQ/IDX read port are implemented as above.
- TX_DRAIN_STATS_EN undefined: no counter registers exist. CNT_OUT and CNT_VALID are tied to 0, and REQ/IDX are ignored. The data path is unchanged.

## Test plan
- Reset then idle:
  - Hold RESET 2 cycles, both FIFOs empty.
  - Expect all outputs 0 during reset, then IDLE=1 and no pops.
- Single word:
  - D0 holds 'b101010, READY_IN=1.
  - Expect POP_D0 at n, DATA_OUT='b0101010 with VALID_OUT=1 at n+2, IDLE=1 at n+3.
- Round robin:
  - D0 holds 3 words, D1 holds 3 words, READY_IN=1.
  - Expect pop order D0,D1,D0,D1,D0,D1 on consecutive cycles.
  - Expect 6 outputs on consecutive cycles with MSB alternating 0,1.
- Backpressure:
  - D1 holds 5 words, READY_IN=0 for 10 cycles, then 1.
  - Expect exactly 3 pops while stalled and DATA_OUT stable.
  - Expect all 5 words delivered in order after release.
- Counters (macro defined):
  - Deliver 33 D0 words and 2 D1 words.
  - Expect IDX=0 to read 1 (wrap), IDX=1 to read 2, IDX=2 to read 3, each one cycle after REQ.
- Reset mid-stream:
  - Assert RESET one cycle after a pop.
  - Expect no VALID_OUT for the in-flight word, counters read 0, pointer back to D0.
